cv32e40p_xif_offload_ctrl: RTL
==============================

CV32E40P_XIF_OFFLOAD_CTRL -- requirements
Module: cv32e40p_xif_offload_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the maximum number of outstanding offloaded instructions (power of two, at least 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the response watchdog limit in cycles (range 1..65535).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have the following core-side offload request ports:
- off_valid_i, input, 1 bit.
- off_ready_o, output, 1 bit.
- off_instr_i, input, 32 bits.
- off_rs_i, input, 3x32 bits.
- off_rd_i, input, 5 bits.
- off_hart_id_i, input, 32 bits.
REQ-006 SHALL have the following C-request channel ports, acting as initiator:
- c_q_valid_o, output, 1 bit.
- c_p_ready_i, input, 1 bit: request accepted.
- c_q_addr_o, output, 5 bits: destination rd.
- c_q_rs_o, output, 3x32 bits.
- c_q_instr_data_o, output, 32 bits.
- c_q_hart_id_o, output, 32 bits.
REQ-007 SHALL have the following C-response channel ports:
- c_p_valid_i, input, 1 bit.
- c_q_ready_o, output, 1 bit.
- c_p_data_i, input, 32 bits.
- c_p_error_i, input, 1 bit.
- c_p_dualwb_i, input, 1 bit.
- c_p_hart_id_i, input, 32 bits.
- c_p_rd_i, input, 5 bits.
REQ-008 SHALL have the following core writeback and status ports:
- wb_valid_o, output, 1 bit.
- wb_rd_o, output, 5 bits.
- wb_data_o, output, 32 bits.
- wb_error_o, output, 1 bit.
- wb_dualwb_o, output, 1 bit.
- outstanding_o, output, clog2(DEPTH+1) bits.
- rd_mismatch_o, output, 1 bit.
- timeout_o, output, 1 bit.

Function
REQ-009 SHALL implement a request state machine with two states, IDLE and ISSUE.
REQ-010 SHALL drive off_ready_o high only in IDLE while fewer than DEPTH instructions are outstanding.
REQ-011 SHALL, on an off_valid_i & off_ready_o handshake, register instruction, operands, rd and hart id onto the c_q_* outputs and enter ISSUE on the next cycle.
REQ-012 SHALL hold c_q_valid_o high and all c_q_* payload stable throughout ISSUE until c_p_ready_i is sampled high.
REQ-013 SHALL, on a c_q_valid_o & c_p_ready_i handshake, push c_q_addr_o into an in-order rd FIFO of DEPTH entries and return to IDLE on the next cycle.
REQ-014 SHALL give a minimum of 2 cycles between successive request handshakes, since off_ready_o is low in ISSUE.
REQ-015 SHALL drive c_q_ready_o high exactly when the rd FIFO is non-empty, so a response with nothing outstanding is never accepted.
REQ-016 SHALL, on a c_p_valid_i & c_q_ready_o handshake, pop the FIFO head and, on the next cycle:
- assert wb_valid_o for exactly 1 cycle;
- drive wb_rd_o = c_p_rd_i, wb_data_o = c_p_data_i and wb_dualwb_o = c_p_dualwb_i;
- drive wb_error_o = c_p_error_i OR (c_p_rd_i != FIFO head) OR (c_p_hart_id_i != hart id of that request).
REQ-017 SHALL set rd_mismatch_o high, sticky until reset, when c_p_rd_i differs from the FIFO head at a response handshake.
REQ-018 SHALL, when a push and a pop occur in the same cycle, perform both and leave outstanding_o unchanged.
REQ-019 SHALL make outstanding_o equal to pushes minus pops, with FIFO pointers wrapping modulo DEPTH.
REQ-020 SHALL never push when full (guaranteed by REQ-010) and never pop when empty (guaranteed by REQ-015).
REQ-021 SHALL hold wb_data_o, wb_rd_o, wb_error_o and wb_dualwb_o at their last values while wb_valid_o is low.

Reset
REQ-022 SHALL, while rst_i is high, immediately force the state to IDLE and clear the FIFO and outstanding_o to 0.
REQ-023 SHALL, while rst_i is high, force c_q_valid_o, wb_valid_o, wb_error_o, wb_dualwb_o, rd_mismatch_o and timeout_o to 0.
REQ-024 SHALL, while rst_i is high, force all c_q_* and wb_* data outputs to 0, and drive off_ready_o 1 and c_q_ready_o 0.
REQ-025 SHALL, on reset asserted mid-ISSUE, drop the pending request without a handshake.

Configuration
REQ-026 SHALL, with macro CV32E40P_XIF_TIMEOUT_EN defined, include a 16-bit watchdog counter with this behaviour:
- counts while the FIFO is non-empty and no response handshake occurs;
- clears to 0 on a response handshake or when the FIFO is empty;
- sets timeout_o high, sticky until reset, when the count reaches TIMEOUT_CYCLES.
REQ-027 SHALL, without CV32E40P_XIF_TIMEOUT_EN, contain no counter and tie timeout_o to constant 0.

Verification
REQ-028 SHALL cover single offload: off_instr_i=0x00A5_8553, rd=10, c_p_ready_i high 2 cycles later, response data 0x3F80_0000 rd=10 -> wb_valid_o one pulse with wb_rd_o=10, wb_data_o=0x3F80_0000, wb_error_o=0.
REQ-029 SHALL cover backpressure: c_p_ready_i low for 5 cycles -> c_q_valid_o high and payload unchanged for 5 cycles, and off_ready_o low throughout.
REQ-030 SHALL cover full: 4 accepted requests with no response -> outstanding_o=4 and off_ready_o=0; one response -> outstanding_o=3 and off_ready_o=1 in IDLE.
REQ-031 SHALL cover simultaneous push and pop at outstanding_o=2 -> outstanding_o stays 2, and FIFO order is preserved across pointer wrap for 10 requests.
REQ-032 SHALL cover rd mismatch: head rd=5, response c_p_rd_i=6 -> wb_error_o=1 and rd_mismatch_o=1 until rst_i.
REQ-033 SHALL cover timeout: macro defined, TIMEOUT_CYCLES=8, one outstanding and no response -> timeout_o=1 after 8 cycles; macro undefined -> timeout_o stays 0.

Source files
------------

// File: rtl/cv32e40p_xif_offload_ctrl.sv
// cv32e40p_xif_offload_ctrl: issues offloaded instructions on the C-request channel and checks in-order responses.
// Optional response watchdog enabled by defining CV32E40P_XIF_TIMEOUT_EN.
module cv32e40p_xif_offload_ctrl #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           off_valid_i,
    output logic                           off_ready_o,
    input  logic [31:0]                    off_instr_i,
    input  logic [2:0][31:0]               off_rs_i,
    input  logic [4:0]                     off_rd_i,
    input  logic [31:0]                    off_hart_id_i,
    output logic                           c_q_valid_o,
    input  logic                           c_p_ready_i,
    output logic [4:0]                     c_q_addr_o,
    output logic [2:0][31:0]               c_q_rs_o,
    output logic [31:0]                    c_q_instr_data_o,
    output logic [31:0]                    c_q_hart_id_o,
    input  logic                           c_p_valid_i,
    output logic                           c_q_ready_o,
    input  logic [31:0]                    c_p_data_i,
    input  logic                           c_p_error_i,
    input  logic                           c_p_dualwb_i,
    input  logic [31:0]                    c_p_hart_id_i,
    input  logic [4:0]                     c_p_rd_i,
    output logic                           wb_valid_o,
    output logic [4:0]                     wb_rd_o,
    output logic [31:0]                    wb_data_o,
    output logic                           wb_error_o,
    output logic                           wb_dualwb_o,
    output logic [$clog2(DEPTH+1)-1:0]     outstanding_o,
    output logic                           rd_mismatch_o,
    output logic                           timeout_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("cv32e40p_xif_offload_ctrl: illegal DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      rd_fifo   [DEPTH];
    logic [31:0]     hart_fifo [DEPTH];
    logic            off_hs, push, pop, rd_bad, hart_bad;

    assign off_hs   = off_valid_i & off_ready_o;
    assign push     = c_q_valid_o & c_p_ready_i;
    assign pop      = c_p_valid_i & c_q_ready_o;
    assign rd_bad   = c_p_rd_i != rd_fifo[rd_ptr];
    assign hart_bad = c_p_hart_id_i != hart_fifo[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE) ? (off_hs ? ISSUE : IDLE) : (c_p_ready_i ? IDLE : ISSUE);
    end

    always_comb begin
        off_ready_o = (state == IDLE) && (outstanding_o < CW'(DEPTH));
        c_q_valid_o = state == ISSUE;
    end

    assign c_q_ready_o = outstanding_o != '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_q_addr_o       <= '0;
            c_q_rs_o         <= '0;
            c_q_instr_data_o <= '0;
            c_q_hart_id_o    <= '0;
        end else if (off_hs) begin
            c_q_addr_o       <= off_rd_i;
            c_q_rs_o         <= off_rs_i;
            c_q_instr_data_o <= off_instr_i;
            c_q_hart_id_o    <= off_hart_id_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            outstanding_o <= outstanding_o + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_fifo[wr_ptr]   <= c_q_addr_o;
            hart_fifo[wr_ptr] <= c_q_hart_id_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_o    <= 1'b0;
            wb_rd_o       <= '0;
            wb_data_o     <= '0;
            wb_error_o    <= 1'b0;
            wb_dualwb_o   <= 1'b0;
            rd_mismatch_o <= 1'b0;
        end else begin
            wb_valid_o    <= pop;
            rd_mismatch_o <= rd_mismatch_o | (pop & rd_bad);
            if (pop) begin
                wb_rd_o     <= c_p_rd_i;
                wb_data_o   <= c_p_data_i;
                wb_error_o  <= c_p_error_i | rd_bad | hart_bad;
                wb_dualwb_o <= c_p_dualwb_i;
            end
        end
    end

`ifdef CV32E40P_XIF_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_run;

    assign wd_run = (outstanding_o != '0) && !pop;

    // Counter saturates at the limit; the flag is sticky so it cannot be missed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            wd_cnt    <= !wd_run ? 16'd0 : (wd_cnt != 16'(TIMEOUT_CYCLES)) ? wd_cnt + 16'd1 : wd_cnt;
            timeout_o <= timeout_o | (wd_run && (wd_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)));
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule
